pc_fetch_seq: RTL and testbench

Fetch-side initiator for the instruction-memory/decoder block (ins_mem). It generates the 8-bit pc address stream and waits the fixed memory read latency. It then captures the returned decoded control bits (regdst, alusrc, memtoreg, regwrite, memread, memwrite, aluop) into a registered bundle with a valid strobe. It supports stall and redirect (branch/jump), and sits between the future next-PC logic and ins_mem.

---
 rtl/pc_fetch_pkg.sv | 49 ++++
 rtl/pc_lat_cnt.sv | 41 ++++
 rtl/pc_fetch_seq.sv | 176 +++++++++++++++++
 tb/tb_pc_fetch_seq.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared definitions for the fetch-side initiator.
//   fetch_state_e : sequencer states (IDLE/ISSUE/WAIT/HALT)
//   CTRL_*        : bit positions of the captured decoder bundle
//   CTRL_W        : width of the captured bundle
//   LAT_CNT_W     : width of the latency down-counter (INS_LAT is 1..3)
//   pack_ctrl()   : assembles the ins_mem control bits into the bundle
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    localparam int unsigned CTRL_W         = 8;
    localparam int unsigned CTRL_REGDST    = 7;
    localparam int unsigned CTRL_ALUSRC    = 6;
    localparam int unsigned CTRL_MEMTOREG  = 5;
    localparam int unsigned CTRL_REGWRITE  = 4;
    localparam int unsigned CTRL_MEMREAD   = 3;
    localparam int unsigned CTRL_MEMWRITE  = 2;
    localparam int unsigned CTRL_ALUOP_MSB = 1;
    localparam int unsigned CTRL_ALUOP_LSB = 0;

    localparam int unsigned LAT_CNT_W = 2;

    function automatic logic [CTRL_W-1:0] pack_ctrl(
        input logic       regdst,
        input logic       alusrc,
        input logic       memtoreg,
        input logic       regwrite,
        input logic       memread,
        input logic       memwrite,
        input logic [1:0] aluop
    );
        logic [CTRL_W-1:0] b;
        b                                = '0;
        b[CTRL_REGDST]                   = regdst;
        b[CTRL_ALUSRC]                   = alusrc;
        b[CTRL_MEMTOREG]                 = memtoreg;
        b[CTRL_REGWRITE]                 = regwrite;
        b[CTRL_MEMREAD]                  = memread;
        b[CTRL_MEMWRITE]                 = memwrite;
        b[CTRL_ALUOP_MSB:CTRL_ALUOP_LSB] = aluop;
        return b;
    endfunction

endpackage

// File: rtl/pc_lat_cnt.sv
// pc_lat_cnt: loadable down-counter timing the ins_mem read latency.
//   clk_i      : clock, rising edge
//   rst_ni     : synchronous active-low reset (count -> 0)
//   load_i     : load load_val_i (takes priority over dec_i)
//   load_val_i : value loaded on load_i
//   dec_i      : decrement request; the count holds at zero
//   zero_o     : count is zero
module pc_lat_cnt #(
    parameter int unsigned W = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pc_fetch_seq.sv
// pc_fetch_seq: fetch-side initiator for ins_mem. Issues the pc stream,
// waits INS_LAT cycles, captures the decoded control bundle with a strobe.
//   clk, rst_n            : clock / synchronous active-low reset
//   en, stall             : run enable / hold the next issue
//   redirect, redirect_pc : squash in-flight fetch, restart at redirect_pc
//   pc, pc_valid          : address to ins_mem, high on the issue cycle
//   regdst..aluop         : decoded controls returned by ins_mem
//   ctrl_q, ctrl_pc       : captured bundle and the pc that produced it
//   ctrl_valid            : one-cycle strobe when ctrl_q/ctrl_pc update
//   halted                : high while halted at PC_LAST
//   ins_cnt               : completed fetch count, saturating
// Build option PC_FETCH_WRAP_EN: wrap to PC_RESET after PC_LAST instead of
// halting.
module pc_fetch_seq
    import pc_fetch_pkg::*;
#(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] PC_RESET = '0,
    parameter logic [PC_W-1:0] PC_LAST  = '1,
    parameter int unsigned     INS_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              stall,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic [PC_W-1:0]   pc,
    output logic              pc_valid,
    input  logic              regdst,
    input  logic              alusrc,
    input  logic              memtoreg,
    input  logic              regwrite,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [1:0]        aluop,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic [PC_W-1:0]   ctrl_pc,
    output logic              ctrl_valid,
    output logic              halted,
    output logic [15:0]       ins_cnt
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(INS_LAT - 1);

    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   next_pc_q, next_pc_d;
    logic [CTRL_W-1:0] ctrl_bundle_q, ctrl_bundle_d;
    logic [PC_W-1:0]   ctrl_pc_q, ctrl_pc_d;
    logic              ctrl_valid_q, ctrl_valid_d;
    logic [15:0]       ins_cnt_q, ins_cnt_d;
    // Set once the current fetch has been captured but stall holds the next issue.
    logic              parked_q, parked_d;

    logic              cnt_load, cnt_dec, cnt_zero;
    logic              go;
    logic              halt_hit;
    logic [PC_W-1:0]   seq_pc;

    pc_lat_cnt #(
        .W(LAT_CNT_W)
    ) u_lat_cnt (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (cnt_load),
        .load_val_i (LAT_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

`ifdef PC_FETCH_WRAP_EN
    assign seq_pc   = (pc_q == PC_LAST) ? PC_RESET : pc_q + PC_W'(1);
    assign halt_hit = 1'b0;
`else
    assign seq_pc   = pc_q + PC_W'(1);
    assign halt_hit = (pc_q == PC_LAST);
`endif

    assign go = en && !stall;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        next_pc_d     = next_pc_q;
        ctrl_bundle_d = ctrl_bundle_q;
        ctrl_pc_d     = ctrl_pc_q;
        ctrl_valid_d  = 1'b0;
        ins_cnt_d     = ins_cnt_q;
        parked_d      = parked_q;
        cnt_load      = 1'b0;
        cnt_dec       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (go) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                pc_d     = next_pc_q;
                cnt_load = 1'b1;
                parked_d = 1'b0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (parked_q) begin
                    if (!en) begin
                        state_d  = ST_IDLE;
                        parked_d = 1'b0;
                    end else if (!stall) begin
                        state_d  = ST_ISSUE;
                        parked_d = 1'b0;
                    end
                end else if (cnt_zero) begin
                    ctrl_bundle_d = pack_ctrl(regdst, alusrc, memtoreg, regwrite,
                                              memread, memwrite, aluop);
                    ctrl_pc_d     = pc_q;
                    ctrl_valid_d  = 1'b1;
                    ins_cnt_d     = (ins_cnt_q == '1) ? ins_cnt_q : ins_cnt_q + 16'd1;
                    next_pc_d     = seq_pc;
                    if (halt_hit)   state_d  = ST_HALT;
                    else if (!en)   state_d  = ST_IDLE;
                    else if (stall) parked_d = 1'b1;
                    else            state_d  = ST_ISSUE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_HALT: begin
            end
        endcase

        // Redirect overrides any capture decided above; an issue in progress
        // still records its pc, only its result is dropped.
        if (redirect) begin
            next_pc_d     = redirect_pc;
            state_d       = go ? ST_ISSUE : ST_IDLE;
            parked_d      = 1'b0;
            ctrl_bundle_d = ctrl_bundle_q;
            ctrl_pc_d     = ctrl_pc_q;
            ctrl_valid_d  = 1'b0;
            ins_cnt_d     = ins_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= PC_RESET;
            next_pc_q     <= PC_RESET;
            ctrl_bundle_q <= '0;
            ctrl_pc_q     <= '0;
            ctrl_valid_q  <= 1'b0;
            ins_cnt_q     <= '0;
            parked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            next_pc_q     <= next_pc_d;
            ctrl_bundle_q <= ctrl_bundle_d;
            ctrl_pc_q     <= ctrl_pc_d;
            ctrl_valid_q  <= ctrl_valid_d;
            ins_cnt_q     <= ins_cnt_d;
            parked_q      <= parked_d;
        end
    end

    // The issue address is presented in the same cycle as pc_valid.
    assign pc         = (state_q == ST_ISSUE) ? next_pc_q : pc_q;
    assign pc_valid   = (state_q == ST_ISSUE);
    assign halted     = (state_q == ST_HALT);
    assign ctrl_q     = ctrl_bundle_q;
    assign ctrl_pc    = ctrl_pc_q;
    assign ctrl_valid = ctrl_valid_q;
    assign ins_cnt    = ins_cnt_q;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// tb_pc_fetch_seq: directed scenarios plus randomized run against a
// cycle-level reference model, on two instances (INS_LAT=1/PC_LAST=FF and
// INS_LAT=3/PC_LAST=3) sharing all inputs.
module tb_pc_fetch_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, stall, redirect;
    logic [7:0]  redirect_pc, mem;
    logic [7:0]  pc1, pc3, cq1, cq3, cpc1, cpc3;
    logic        pv1, pv3, cv1, cv3, h1, h3;
    logic [15:0] ic1, ic3;
    int          checks = 0;
    int          errors = 0;
    bit          mem_rand = 1'b0;

    pc_fetch_seq #(.PC_W(8), .PC_RESET(8'h00), .PC_LAST(8'hFF), .INS_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .pc(pc1), .pc_valid(pv1),
        .regdst(mem[7]), .alusrc(mem[6]), .memtoreg(mem[5]), .regwrite(mem[4]),
        .memread(mem[3]), .memwrite(mem[2]), .aluop(mem[1:0]),
        .ctrl_q(cq1), .ctrl_pc(cpc1), .ctrl_valid(cv1), .halted(h1), .ins_cnt(ic1)
    );

    pc_fetch_seq #(.PC_W(8), .PC_RESET(8'h00), .PC_LAST(8'h03), .INS_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .pc(pc3), .pc_valid(pv3),
        .regdst(mem[7]), .alusrc(mem[6]), .memtoreg(mem[5]), .regwrite(mem[4]),
        .memread(mem[3]), .memwrite(mem[2]), .aluop(mem[1:0]),
        .ctrl_q(cq3), .ctrl_pc(cpc3), .ctrl_valid(cv3), .halted(h3), .ins_cnt(ic3)
    );

    // Reference model: per instance, age counts cycles since the issue
    // (-1 = no fetch in flight); a fetch completes when age reaches its latency.
    int         m_lat  [2] = '{1, 3};
    logic [7:0] m_lastp[2] = '{8'hFF, 8'h03};
    int         m_age  [2];
    bit         m_park [2];
    bit         m_halt [2];
    bit         m_cv   [2];
    logic [7:0] m_last [2];
    logic [7:0] m_next [2];
    logic [7:0] m_cq   [2];
    logic [7:0] m_cpc  [2];
    int         m_cnt  [2];

    function automatic void model_step();
        for (int k = 0; k < 2; k++) begin
            m_cv[k] = 1'b0;
            if (!rst_n) begin
                m_age[k] = -1; m_park[k] = 1'b0; m_halt[k] = 1'b0;
                m_last[k] = 8'h00; m_next[k] = 8'h00;
                m_cq[k] = 8'h00; m_cpc[k] = 8'h00; m_cnt[k] = 0;
                continue;
            end
            if (m_age[k] == 0) m_last[k] = m_next[k];
            if (redirect) begin
                m_next[k] = redirect_pc;
                m_halt[k] = 1'b0;
                m_park[k] = 1'b0;
                m_age[k]  = (en && !stall) ? 0 : -1;
                continue;
            end
            if (m_halt[k]) continue;
            if (m_age[k] == -1) begin
                if (en && !stall) m_age[k] = 0;
            end else if (m_park[k]) begin
                if (!en) begin
                    m_park[k] = 1'b0; m_age[k] = -1;
                end else if (!stall) begin
                    m_park[k] = 1'b0; m_age[k] = 0;
                end
            end else if (m_age[k] < m_lat[k]) begin
                m_age[k]++;
            end else begin
                m_cv[k]  = 1'b1;
                m_cq[k]  = mem;
                m_cpc[k] = m_last[k];
                if (m_cnt[k] < 65535) m_cnt[k]++;
`ifdef PC_FETCH_WRAP_EN
                m_next[k] = (m_last[k] == m_lastp[k]) ? 8'h00 : 8'(m_last[k] + 8'd1);
                if (!en)        m_age[k]  = -1;
                else if (stall) m_park[k] = 1'b1;
                else            m_age[k]  = 0;
`else
                m_next[k] = 8'(m_last[k] + 8'd1);
                if (m_last[k] == m_lastp[k]) begin
                    m_halt[k] = 1'b1; m_age[k] = -1;
                end
                else if (!en)   m_age[k]  = -1;
                else if (stall) m_park[k] = 1'b1;
                else            m_age[k]  = 0;
`endif
            end
        end
    endfunction

    // {pc, pc_valid, ctrl_q, ctrl_pc, ctrl_valid, halted, ins_cnt}
    function automatic logic [42:0] model_out(input int k);
        logic       iss;
        logic [7:0] p;
        iss = (m_age[k] == 0);
        p   = iss ? m_next[k] : m_last[k];
        return {p, iss, m_cq[k], m_cpc[k], m_cv[k], m_halt[k], 16'(m_cnt[k])};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (mem_rand) mem = 8'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; redirect = 1'b0; stall = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1;
        tick(); tick();
        checks++;
        if ({pc1, pv1, cq1, cpc1, cv1, h1, ic1} !== 43'd0) begin
            errors++; $display("FAIL reset_dut1: got %h expected 0", {pc1, pv1, cq1, cpc1, cv1, h1, ic1});
        end
        checks++;
        if ({pc3, pv3, cq3, cpc3, cv3, h3, ic3} !== 43'd0) begin
            errors++; $display("FAIL reset_dut3: got %h expected 0", {pc3, pv3, cq3, cpc3, cv3, h3, ic3});
        end
    endtask

    task automatic test_stream();
        int nis = 0, ncv = 0, cyc = 0;
        int iss_cyc[8];
        en = 1'b0; do_reset();
        mem_rand = 1'b0; mem = 8'h92; en = 1'b1;
        for (int i = 0; i < 30 && ncv < 4; i++) begin
            tick(); cyc++;
            if (pv1) begin
                checks++;
                if (pc1 !== 8'(nis)) begin
                    errors++; $display("FAIL stream_pc: got %h expected %h", pc1, 8'(nis));
                end
                if (nis > 0) begin
                    checks++;
                    if (cyc - iss_cyc[nis-1] !== 2) begin
                        errors++; $display("FAIL stream_rate: got %0d expected 2", cyc - iss_cyc[nis-1]);
                    end
                end
                if (nis < 8) iss_cyc[nis] = cyc;
                nis++;
            end
            if (cv1) begin
                checks++;
                if ({cq1, cpc1} !== {8'h92, 8'(ncv)} || cyc - iss_cyc[ncv] !== 2) begin
                    errors++; $display("FAIL stream_ctrl: got q=%h pc=%h lat=%0d expected q=92 pc=%h lat=2",
                                       cq1, cpc1, cyc - iss_cyc[ncv], 8'(ncv));
                end
                ncv++;
                if (ncv == 4) begin
                    checks++;
                    if (ic1 !== 16'd4) begin
                        errors++; $display("FAIL stream_cnt: got %0d expected 4", ic1);
                    end
                end
            end
        end
        checks++;
        if (ncv !== 4) begin
            errors++; $display("FAIL stream_timeout: got %0d completions expected 4", ncv);
        end
    endtask

    task automatic test_stall();
        bit found = 1'b0;
        int cvs = 0;
        en = 1'b1; do_reset(); mem_rand = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (pv1 && pc1 == 8'h01) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) begin
            errors++; $display("FAIL stall_wait: got no issue of pc 01 expected one");
        end
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (pv1 !== 1'b0) begin
                errors++; $display("FAIL stall_no_issue: got pc_valid=%b pc=%h expected 0", pv1, pc1);
            end
            if (cv1) begin
                cvs++;
                checks++;
                if (cpc1 !== 8'h01) begin
                    errors++; $display("FAIL stall_ctrl_pc: got %h expected 01", cpc1);
                end
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if ({pv1, pc1, cv1} !== {1'b1, 8'h02, 1'b0}) begin
            errors++; $display("FAIL stall_resume: got pv=%b pc=%h cv=%b expected pv=1 pc=02 cv=0", pv1, pc1, cv1);
        end
        checks++;
        if (cvs !== 1) begin
            errors++; $display("FAIL stall_dup: got %0d strobes expected 1", cvs);
        end
    endtask

    task automatic test_redirect();
        bit found = 1'b0;
        en = 1'b1; stall = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (pv1 && pc1 == 8'h05) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) begin
            errors++; $display("FAIL redir_wait: got no issue of pc 05 expected one");
        end
        tick();
        redirect = 1'b1; redirect_pc = 8'h40;
        tick();
        redirect = 1'b0;
        checks++;
        if ({pv1, pc1, cv1, ic1} !== {1'b1, 8'h40, 1'b0, 16'd5}) begin
            errors++; $display("FAIL redir_issue: got pv=%b pc=%h cv=%b cnt=%0d expected pv=1 pc=40 cv=0 cnt=5",
                               pv1, pc1, cv1, ic1);
        end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (cv1) found = 1'b1;
        end
        checks++;
        if ({found, cpc1, ic1} !== {1'b1, 8'h40, 16'd6}) begin
            errors++; $display("FAIL redir_next: got seen=%b pc=%h cnt=%0d expected seen=1 pc=40 cnt=6",
                               found, cpc1, ic1);
        end
    endtask

    task automatic test_halt();
        en = 1'b1; do_reset(); mem_rand = 1'b1;
`ifdef PC_FETCH_WRAP_EN
        begin
            int n = 0;
            for (int i = 0; i < 80 && n < 6; i++) begin
                tick();
                if (pv3) begin
                    checks++;
                    if (pc3 !== 8'(n % 4)) begin
                        errors++; $display("FAIL wrap_pc: got %h expected %h", pc3, 8'(n % 4));
                    end
                    n++;
                end
            end
            checks++;
            if (n !== 6) begin
                errors++; $display("FAIL wrap_timeout: got %0d issues expected 6", n);
            end
        end
`else
        begin
            bit found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                tick();
                if (cv3 && cpc3 == 8'h03) found = 1'b1;
            end
            checks++;
            if ({found, h3, pv3, pc3, ic3} !== {1'b1, 1'b1, 1'b0, 8'h03, 16'd4}) begin
                errors++; $display("FAIL halt_enter: got seen=%b halted=%b pv=%b pc=%h cnt=%0d expected 1 1 0 03 4",
                                   found, h3, pv3, pc3, ic3);
            end
            for (int i = 0; i < 4; i++) begin
                tick();
                checks++;
                if ({h3, pv3, pc3} !== {1'b1, 1'b0, 8'h03}) begin
                    errors++; $display("FAIL halt_hold: got halted=%b pv=%b pc=%h expected 1 0 03", h3, pv3, pc3);
                end
            end
            redirect = 1'b1; redirect_pc = 8'h00;
            tick();
            redirect = 1'b0;
            checks++;
            if ({h3, pv3, pc3} !== {1'b0, 1'b1, 8'h00}) begin
                errors++; $display("FAIL halt_exit: got halted=%b pv=%b pc=%h expected 0 1 00", h3, pv3, pc3);
            end
        end
`endif
    endtask

    task automatic test_reset_midwait();
        bit found = 1'b0;
        en = 1'b1; do_reset(); mem_rand = 1'b0; mem = 8'hA5;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (pv3 && pc3 == 8'h02) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) begin
            errors++; $display("FAIL rstmid_wait: got no issue of pc 02 expected one");
        end
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({pc3, pv3, cq3, cpc3, cv3, h3, ic3} !== 43'd0) begin
            errors++; $display("FAIL rstmid_state: got %h expected 0", {pc3, pv3, cq3, cpc3, cv3, h3, ic3});
        end
        tick();
        checks++;
        if ({pv3, pc3, cv3} !== {1'b1, 8'h00, 1'b0}) begin
            errors++; $display("FAIL rstmid_restart: got pv=%b pc=%h cv=%b expected 1 00 0", pv3, pc3, cv3);
        end
    endtask

    task automatic test_saturate();
        int n = 0;
        en = 1'b0; do_reset(); mem_rand = 1'b1;
        tick();
        force dut1.ins_cnt_q = 16'hFFFE;
        tick();
        release dut1.ins_cnt_q;
        m_cnt[0] = 32'hFFFE;
        checks++;
        if (ic1 !== 16'hFFFE) begin
            errors++; $display("FAIL sat_preset: got %h expected fffe", ic1);
        end
        en = 1'b1;
        for (int i = 0; i < 30 && n < 3; i++) begin
            tick();
            if (cv1) begin
                n++;
                checks++;
                if (ic1 !== 16'hFFFF) begin
                    errors++; $display("FAIL sat_cnt: got %h expected ffff after %0d", ic1, n);
                end
            end
        end
        checks++;
        if (n !== 3) begin
            errors++; $display("FAIL sat_timeout: got %0d completions expected 3", n);
        end
    endtask

    task automatic test_random();
        en = 1'b1; do_reset(); mem_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            en          = ($urandom_range(0, 9) != 0);
            stall       = ($urandom_range(0, 4) == 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            rst_n       = ($urandom_range(0, 199) != 0);
            tick();
            checks++;
            if ({pc1, pv1, cq1, cpc1, cv1, h1, ic1} !== model_out(0)) begin
                errors++; $display("FAIL rand_dut1 @%0d: got %h expected %h", i,
                                   {pc1, pv1, cq1, cpc1, cv1, h1, ic1}, model_out(0));
            end
            checks++;
            if ({pc3, pv3, cq3, cpc3, cv3, h3, ic3} !== model_out(1)) begin
                errors++; $display("FAIL rand_dut3 @%0d: got %h expected %h", i,
                                   {pc3, pv3, cq3, cpc3, cv3, h3, ic3}, model_out(1));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_pc = 8'h00; mem = 8'h00;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_halt();
        test_reset_midwait();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
